// File: rtl/inputcond_pkg.sv
// Purpose : shared defaults and parameter-legality helpers for the input conditioner array.
// Latency : n/a (constants and elaboration-time functions only).
// Backpr. : n/a.
package inputcond_pkg;

    localparam int DEF_CHANNELS      = 4;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_WAITTIME      = 3;
    localparam int DEF_COUNTER_WIDTH = 3;

    // Number of bits needed to hold 'value' (clog2(value+1)); 0 needs 0 bits.
    function automatic int bits_needed(input int value);
        int n;
        int v;
        n = 0;
        v = value;
        while (v > 0) begin
            n = n + 1;
            v = v >> 1;
        end
        return n;
    endfunction

    // Legal when the synchroniser has at least two flops and the debounce
    // counter can reach WAITTIME without wrapping (2^COUNTER_WIDTH > WAITTIME).
    function automatic bit config_ok(input int sync_stages,
                                     input int waittime,
                                     input int counter_width);
        return (sync_stages >= 2) &&
               (waittime >= 0) &&
               (counter_width >= 1) &&
               (counter_width >= bits_needed(waittime));
    endfunction

endpackage

// File: rtl/inputconditioner_channel.sv
// Purpose : one channel: synchroniser chain, debounce counter, registered edge pulses.
// Latency : clean step shows on conditioned SYNC_STAGES+WAITTIME+1 edges after first sample.
// Backpr. : none; free-running, output valid every cycle.
//
// Ports: clk, reset (sync, active-high), noisysignal (async raw input),
//        conditioned (debounced level), positiveedge / negativeedge (1-cycle pulses).
module inputconditioner_channel
    import inputcond_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int   WAITTIME      = DEF_WAITTIME,
    parameter int   COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic noisysignal,
    output logic conditioned,
    output logic positiveedge,
    output logic negativeedge
);

    if (!config_ok(SYNC_STAGES, WAITTIME, COUNTER_WIDTH)) begin : g_bad_cfg
        $error("inputconditioner_channel: illegal SYNC_STAGES/WAITTIME/COUNTER_WIDTH combination");
    end

    localparam logic [COUNTER_WIDTH-1:0] WAIT_MAX = COUNTER_WIDTH'(WAITTIME);

    logic [SYNC_STAGES-1:0]   sync_q,         sync_d;
    logic [COUNTER_WIDTH-1:0] count_q,        count_d;
    logic                     conditioned_q,  conditioned_d;
    logic                     positiveedge_q, positiveedge_d;
    logic                     negativeedge_q, negativeedge_d;
    logic                     sync_out;

    // Oldest synchroniser stage is the only one the debounce logic may look at.
    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d         = {sync_q[SYNC_STAGES-2:0], noisysignal};
        count_d        = count_q;
        conditioned_d  = conditioned_q;
        positiveedge_d = 1'b0;
        negativeedge_d = 1'b0;

        if (sync_out == conditioned_q) begin
            // Any agreeing sample restarts the debounce window.
            count_d = '0;
        end else if (count_q == WAIT_MAX) begin
            // WAITTIME+1 consecutive disagreeing samples: commit and pulse.
            conditioned_d  = sync_out;
            count_d        = '0;
            positiveedge_d = sync_out;
            negativeedge_d = ~sync_out;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Reset loads the level silently: no pulse even if conditioned moves.
            sync_q         <= {SYNC_STAGES{RESET_VALUE}};
            count_q        <= '0;
            conditioned_q  <= RESET_VALUE;
            positiveedge_q <= 1'b0;
            negativeedge_q <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            count_q        <= count_d;
            conditioned_q  <= conditioned_d;
            positiveedge_q <= positiveedge_d;
            negativeedge_q <= negativeedge_d;
        end
    end

    assign conditioned  = conditioned_q;
    assign positiveedge = positiveedge_q;
    assign negativeedge = negativeedge_q;

endmodule

// File: rtl/input_conditioner_array.sv
// Purpose : CHANNELS independent input conditioners plus an aggregated any-edge flag.
// Latency : per channel SYNC_STAGES+WAITTIME+1 edges; anyedge is combinational from registered pulses.
// Backpr. : none; free-running, outputs valid every cycle.
//
// Ports: clk, reset (sync, active-high), noisysignal[CHANNELS] (async raw inputs),
//        conditioned / positiveedge / negativeedge [CHANNELS], anyedge (OR of all pulses).
module input_conditioner_array
    import inputcond_pkg::*;
#(
    parameter int                  CHANNELS      = DEF_CHANNELS,
    parameter int                  SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int                  WAITTIME      = DEF_WAITTIME,
    parameter int                  COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisysignal,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    output logic                anyedge
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        inputconditioner_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .WAITTIME      (WAITTIME),
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .RESET_VALUE   (RESET_VALUE[i])
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .noisysignal  (noisysignal[i]),
            .conditioned  (conditioned[i]),
            .positiveedge (positiveedge[i]),
            .negativeedge (negativeedge[i])
        );
    end

    assign anyedge = |(positiveedge | negativeedge);

endmodule

// File: doc/input_conditioner_array.md
# input_conditioner_array

Parametrised, multi-channel successor to the single-bit input conditioner. Each of `CHANNELS` asynchronous, possibly bouncing inputs (SPI pins, buttons, chip-select lines) is synchronised into the `clk` domain through `SYNC_STAGES` flops, debounced over `WAITTIME` cycles, and given one-cycle rising and falling edge pulses. It adds a synchronous reset, per-channel reset values, and an aggregated any-edge flag for downstream FSMs.

## Interface
- `CHANNELS`, 4, number of independent input channels (>= 1)
- `SYNC_STAGES`, 2, synchroniser depth in flops (>= 2)
- `WAITTIME`, 3, debounce delay in cycles (>= 0)
- `COUNTER_WIDTH`, 3, debounce counter width; must satisfy 2^COUNTER_WIDTH > WAITTIME
- `RESET_VALUE`, {CHANNELS{1'b0}}, per-channel value loaded into synchroniser flops and `conditioned` on reset
- `clk` input 1: the single clock; all state updates on its rising edge
- `reset` input 1: synchronous, active-high reset
- `noisysignal` input CHANNELS: raw asynchronous inputs, one bit per channel
- `conditioned` output CHANNELS: debounced, synchronised level per channel
- `positiveedge` output CHANNELS: one-cycle pulse when `conditioned[i]` rises
- `negativeedge` output CHANNELS: one-cycle pulse when `conditioned[i]` falls
- `anyedge` output 1: OR of all `positiveedge` and `negativeedge` bits, same cycle

## Operation
- Channels are fully independent. No cross-channel interaction exists except `anyedge`.
- Per channel: a shift chain `sync[0..SYNC_STAGES-1]`. Let `s = sync[SYNC_STAGES-1]`.
- Each edge, when not in reset:
  - `s == conditioned`: counter <= 0; both pulses <= 0.
  - `s != conditioned` and counter == WAITTIME: conditioned <= s; counter <= 0; `positiveedge` <= s; `negativeedge` <= ~s.
  - `s != conditioned` and counter < WAITTIME: counter <= counter+1; both pulses <= 0.
- A mismatch must persist for WAITTIME+1 consecutive samples of `s` before `conditioned` changes.
- Any sample where `s` equals `conditioned` restarts the count. Glitches of WAITTIME samples or fewer never propagate.
- Counter never exceeds WAITTIME and never wraps.
- Reset (`reset` high at an edge):
  - all `sync` flops and `conditioned[i]` <= `RESET_VALUE[i]`
  - counters <= 0
  - `positiveedge`, `negativeedge` <= 0; `anyedge` is therefore 0
- Reset generates no edge pulse, even when it changes `conditioned`.
- Reset mid-debounce discards the partial count.
- Reset dominates every other condition in the same cycle.

## Timing
- All outputs are registered except `anyedge`, which is combinational from registered pulses.
- Latency: a clean step on `noisysignal[i]`, first sampled at edge 0, appears on `conditioned[i]` after edge SYNC_STAGES+WAITTIME+1. Defaults give 6 edges.
- `positiveedge`/`negativeedge` are high in exactly the cycle `conditioned` first shows its new value, and low the following cycle.
- After a committed change, `s` already equals `conditioned`, so the next change needs a fresh full debounce window.
- WAITTIME=0: output follows `s` one cycle later, with edge pulses.
- Simultaneous edges on different channels pulse in the same cycle. `anyedge` is high once for that cycle.
- `positiveedge[i]` and `negativeedge[i]` are never high together.

## Structure
- Shared package `inputcond_pkg`:
  - default parameter constants
  - a `clog2`-style width check used to assert `2^COUNTER_WIDTH > WAITTIME` and `SYNC_STAGES >= 2` at elaboration
- Sub-module `inputconditioner_channel`: one channel's synchroniser, counter and edge logic, with scalar `RESET_VALUE`. It is instantiated `CHANNELS` times by a generate loop.
- The top level holds only the generate loop and the `anyedge` OR-reduction.

## Test plan
- Reset: `RESET_VALUE=4'b0101`, reset high 2 cycles, then released with inputs held at 4'b0101. Required: `conditioned`=4'b0101 and all pulses 0 throughout, no pulse after release.
- Clean step: ch0 0->1 before edge 0, defaults. Required: `conditioned[0]` rises after edge 6; `positiveedge[0]` and `anyedge` high for exactly that one cycle; other channels unchanged.
- Bounce: ch1 toggles high for 3 cycles, low for 1, then high steady. Required: no change until 4 consecutive matching `s` samples; exactly one `positiveedge[1]`, zero `negativeedge[1]`.
- Falling edge plus simultaneity: ch2 and ch3 both fall in the same cycle from 1. Required: `negativeedge[3:2]`=2'b11 in the same cycle; `anyedge` high for one cycle.
- Reset mid-debounce: ch0 rising with counter at 2, reset asserted for 1 cycle, input held high. Required: `conditioned[0]` rises SYNC_STAGES+WAITTIME+1 edges after reset release, with no pulse during reset.
- Parameter sweep: `CHANNELS=1`/`SYNC_STAGES=3`/`WAITTIME=0` and `CHANNELS=8`/`WAITTIME=7`/`COUNTER_WIDTH=3`. Required: latency equals SYNC_STAGES+WAITTIME+1 in each; an illegal `COUNTER_WIDTH=2`, `WAITTIME=4` fails elaboration.
